// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Command sequencer that drives the operand and opcode inputs of an 8-bit
// combinational ALU. The accumulator is operand A. EXEC commands can repeat
// one operation several times, for example to build a multi-bit shift.
// Results are returned on a valid/ready response port.
//
// Optional feature: when ALU_SEQ_STICKY_V_EN is defined, the block gains a
// sticky_v output. It records any overflow seen during EXEC and is cleared
// only by CLRF or by reset.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cmd_ready high; waiting for a command
// EXEC  | one ALU evaluation per cycle; acc/flags captured each edge
// RESP  | response raised one cycle after entry, held until rsp_ready

module alu_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int REP_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [REP_W-1:0]  cmd_rep,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              alu_n,
  input  logic              alu_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        rsp_flags,
`ifdef ALU_SEQ_STICKY_V_EN
  output logic              sticky_v,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] KIND_LOAD = 2'b00;
  localparam logic [1:0] KIND_EXEC = 2'b01;
  localparam logic [1:0] KIND_CLRF = 2'b10;

  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [3:0]        flags;
  logic [REP_W-1:0]  count;
  logic              accept;

  // A command is accepted only while cmd_ready is high, and that happens only in IDLE.
  assign accept = cmd_valid & cmd_ready;

  // The ALU sees the accumulator directly. The response port always shows the live registers.
  assign alu_a     = acc;
  assign rsp_data  = acc;
  assign rsp_flags = flags;

  // Sequencer FSM with registered handshake outputs and datapath captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      flags     <= '0;
      count     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ALU_SEQ_STICKY_V_EN
      sticky_v  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (cmd_kind)
              KIND_LOAD: begin
                acc   <= cmd_data;
                state <= ST_RESP;
              end
              KIND_EXEC: begin
                alu_op <= cmd_op;
                alu_b  <= cmd_data;
                // A repeat count of zero is treated as a single evaluation.
                count  <= (cmd_rep == '0) ? REP_ONE : cmd_rep;
                state  <= ST_EXEC;
              end
              KIND_CLRF: begin
                flags <= '0;
`ifdef ALU_SEQ_STICKY_V_EN
                sticky_v <= 1'b0;
`endif
                state <= ST_RESP;
              end
              default: begin
                state <= ST_RESP;
              end
            endcase
          end
        end

        ST_EXEC: begin
          acc   <= alu_y;
          flags <= {alu_c, alu_v, alu_n, alu_z};
`ifdef ALU_SEQ_STICKY_V_EN
          if (alu_v) begin
            sticky_v <= 1'b1;
          end
`endif
          if (count > REP_ONE) begin
            count <= count - REP_ONE;
          end else begin
            count <= '0;
            state <= ST_RESP;
          end
        end

        ST_RESP: begin
          // rsp_valid goes high one cycle after entering RESP and holds until the transfer.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
